// File: rtl/bcd_pkg.sv
// Shared BCD digit type, digit limits and load saturation helper.
// Pure definitions: no latency, no flow control.
package bcd_pkg;
   localparam logic [3:0] BCD_MAX = 4'd9;
   localparam logic [3:0] BCD_MIN = 4'd0;

   typedef logic [3:0] bcd_digit_t;

   function automatic bcd_digit_t sat_bcd(input bcd_digit_t d);
      return (d > BCD_MAX) ? BCD_MAX : d;
   endfunction
endpackage

// File: rtl/bcd_digit.sv
// One registered BCD digit with clear > load > step priority.
// Latency: 1 mclk from en/clr/ld to q; no backpressure.
module bcd_digit
   import bcd_pkg::*;
(
   input  logic       mclk,
   input  logic       reset,
   input  logic       en,
   input  logic       up,
   input  logic       clr,
   input  logic       ld,
   input  bcd_digit_t ld_val,
   output bcd_digit_t q,
   output logic       term
);
   bcd_digit_t q_q;
   bcd_digit_t q_d;

   always_comb begin
      q_d = q_q;
      if (clr) begin
         q_d = BCD_MIN;
      end else if (ld) begin
         q_d = sat_bcd(ld_val);
      end else if (en) begin
         if (up) begin
            q_d = (q_q >= BCD_MAX) ? BCD_MIN : q_q + 4'd1;
         end else begin
            // Out-of-range values cannot occur, but fold them to 9 defensively.
            q_d = (q_q == BCD_MIN || q_q > BCD_MAX) ? BCD_MAX : q_q - 4'd1;
         end
      end
   end

   always_ff @(posedge mclk or posedge reset) begin
      if (reset) q_q <= BCD_MIN;
      else       q_q <= q_d;
   end

   assign q    = q_q;
   assign term = up ? (q_q == BCD_MAX) : (q_q == BCD_MIN);
endmodule

// File: rtl/bcd_cascade_counter.sv
// Cascaded BCD counter advanced by rising edges of clk_div sampled on mclk; BCD_DOWN_EN adds up_dn.
// Latency: count steps at the mclk edge that first samples clk_div high; no backpressure (hold freezes).
module bcd_cascade_counter
   import bcd_pkg::*;
#(
   parameter int DIGITS = 4
) (
   input  logic                  mclk,
   input  logic                  reset,
   input  logic                  clk_div,
   input  logic                  clr,
   input  logic                  hold,
   input  logic                  load,
   input  logic [4*DIGITS-1:0]   load_val,
`ifdef BCD_DOWN_EN
   input  logic                  up_dn,
`endif
   output logic [4*DIGITS-1:0]   bcd,
   output logic                  carry,
   output logic                  tick
);
   logic clk_div_q, clk_div_d;
   logic tick_q, tick_d;
   logic carry_q, carry_d;
   logic tick_c;
   logic step;
   logic up;
   logic [DIGITS-1:0] term_w;
   logic [DIGITS-1:0] en_w;

`ifdef BCD_DOWN_EN
   assign up = up_dn;
`else
   assign up = 1'b1;
`endif

   assign tick_c = clk_div & ~clk_div_q;
   assign step   = tick_c & ~hold;

   always_comb begin
      clk_div_d = clk_div;
      tick_d    = tick_c;
      carry_d   = step & ~clr & ~load & (&term_w);
   end

   // clk_div_q resets high so a clk_div already high at release is not seen as an edge.
   always_ff @(posedge mclk or posedge reset) begin
      if (reset) begin
         clk_div_q <= 1'b1;
         tick_q    <= 1'b0;
         carry_q   <= 1'b0;
      end else begin
         clk_div_q <= clk_div_d;
         tick_q    <= tick_d;
         carry_q   <= carry_d;
      end
   end

   for (genvar i = 0; i < DIGITS; i++) begin : g_digit
      if (i == 0) begin : g_lsd
         assign en_w[i] = step;
      end else begin : g_upper
         assign en_w[i] = step & (&term_w[i-1:0]);
      end

      bcd_digit u_digit (
         .mclk   (mclk),
         .reset  (reset),
         .en     (en_w[i]),
         .up     (up),
         .clr    (clr),
         .ld     (load),
         .ld_val (load_val[4*i +: 4]),
         .q      (bcd[4*i +: 4]),
         .term   (term_w[i])
      );
   end

   assign carry = carry_q;
   assign tick  = tick_q;
endmodule
